// File: rtl/load_store_unit.sv
`default_nettype none
//============================================================================
// Module   : load_store_unit
// Summary  : Memory stage - sized loads/stores, sub-word RMW, misalign/timeout
// Revision : 1.0
//============================================================================
module load_store_unit #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [1:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_RD_WAIT  = 3'd1;
  localparam logic [2:0] c_RMW_WAIT = 3'd2;
  localparam logic [2:0] c_WRITE    = 3'd3;
  localparam logic [2:0] c_RESP     = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]       r_state;
  logic [1:0]       r_op;
  logic [1:0]       r_size;
  logic [1:0]       r_byteOff;
  logic [15:0]      r_storeData;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_respData;
  logic [4:0]       r_respRd;
  logic             r_respErr;
  logic [1:0]       r_memOp;
  logic [31:0]      r_memAddr;
  logic [31:0]      r_memWdata;

  logic        w_accept;
  logic        w_badReq;
  logic        w_expired;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;
  logic [31:0] w_mergeData;

  assign req_ready  = (r_state == c_IDLE);
  assign resp_valid = (r_state == c_RESP);
  assign resp_data  = r_respData;
  assign resp_rd    = r_respRd;
  assign resp_err   = r_respErr;
  assign mem_op     = r_memOp;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;

  assign w_accept  = req_valid & req_ready;
  assign w_badReq  = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
  assign w_expired = (r_count == CNT_W'(TIMEOUT - 1));

  // Lane selection and extension of the returned word for loads
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_byteOff)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_byteOff[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   w_loadData = (r_op == MEM_READ_SEXT) ? {{24{w_byte[7]}}, w_byte}
                                                    : {24'h0, w_byte};
      2'b01:   w_loadData = (r_op == MEM_READ_SEXT) ? {{16{w_half[15]}}, w_half}
                                                    : {16'h0, w_half};
      default: w_loadData = mem_rdata;
    endcase
  end

  // Sub-word store: replace only the addressed lane of the fetched word
  always_comb begin
    w_mergeData = mem_rdata;
    if (r_size == 2'b00) begin
      case (r_byteOff)
        2'd1:    w_mergeData[15:8]  = r_storeData[7:0];
        2'd2:    w_mergeData[23:16] = r_storeData[7:0];
        2'd3:    w_mergeData[31:24] = r_storeData[7:0];
        default: w_mergeData[7:0]   = r_storeData[7:0];
      endcase
    end else if (r_byteOff[1]) begin
      w_mergeData[31:16] = r_storeData;
    end else begin
      w_mergeData[15:0] = r_storeData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_op        <= MEM_DISABLE;
      r_size      <= 2'b00;
      r_byteOff   <= 2'b00;
      r_storeData <= 16'h0;
      r_count     <= '0;
      r_respData  <= 32'h0;
      r_respRd    <= 5'h0;
      r_respErr   <= 1'b0;
      r_memOp     <= MEM_DISABLE;
      r_memAddr   <= 32'h0;
      r_memWdata  <= 32'h0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_op        <= req_op;
            r_size      <= req_size;
            r_byteOff   <= req_addr[1:0];
            r_storeData <= req_wdata[15:0];
            r_count     <= '0;
            r_respData  <= 32'h0;
            r_respRd    <= req_rd;
            r_respErr   <= 1'b0;
            r_memAddr   <= {req_addr[31:2], 2'b00};
            if (w_badReq) begin
              r_respErr <= 1'b1;
              r_state   <= c_RESP;
            end else if (req_op == MEM_DISABLE) begin
              r_state <= c_RESP;
            end else if (req_op != MEM_WRITE) begin
              r_memOp <= MEM_READ_SEXT;
              r_state <= c_RD_WAIT;
            end else if (req_size == 2'b10) begin
              r_memWdata <= req_wdata;
              r_memOp    <= MEM_WRITE;
              r_state    <= c_WRITE;
            end else begin
              r_memOp <= MEM_READ_SEXT;
              r_state <= c_RMW_WAIT;
            end
          end
        end
        c_RD_WAIT: begin
          r_memOp <= MEM_DISABLE;
          if (mem_rvalid) begin
            r_respData <= w_loadData;
            r_state    <= c_RESP;
          end else if (w_expired) begin
            r_respErr <= 1'b1;
            r_state   <= c_RESP;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        c_RMW_WAIT: begin
          r_memOp <= MEM_DISABLE;
          if (mem_rvalid) begin
            r_memWdata <= w_mergeData;
            r_memOp    <= MEM_WRITE;
            r_state    <= c_WRITE;
          end else if (w_expired) begin
            r_respErr <= 1'b1;
            r_state   <= c_RESP;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        c_WRITE: begin
          r_memOp <= MEM_DISABLE;
          r_state <= c_RESP;
        end
        c_RESP: begin
          if (resp_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_memOp <= MEM_DISABLE;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
